// File: rtl/chain_test_sequencer_pkg.sv
// Shared types for the scan-chain test sequencer: FSM state encoding and the
// per-step pass/fail compare used in the CHECK state.
package chain_test_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST_DUT,
      APPLY,
      CHECK,
      NEXT,
      PAUSE,
      DONE
   } seq_state_t;

   localparam int MAX_PATTERN_W = 32;

   // A step passes only when the chain echoes exactly the pattern that was applied.
   function automatic logic is_mismatch(input logic [MAX_PATTERN_W-1:0] chain_input,
                                        input logic [MAX_PATTERN_W-1:0] chain_output,
                                        input logic [MAX_PATTERN_W-1:0] pattern);
      return !((chain_output == chain_input) && (chain_input == pattern));
   endfunction

endpackage

// File: rtl/chain_test_sequencer_if.sv
// Control, chain-side and status signals of the scan-chain test sequencer.
// The master modport is the sequencer itself; slave is the tester/display side.
interface chain_test_sequencer_if #(
   parameter int PATTERN_W = 6,
   parameter int MUX_W     = 5,
   parameter int CNT_W     = 15
);
   logic                 start;
   logic                 abort;
   logic                 halt_on_err;
   logic                 continua;
   logic [PATTERN_W-1:0] chain_input;
   logic [PATTERN_W-1:0] chain_output;
   logic [PATTERN_W-1:0] K;
   logic [MUX_W-1:0]     mux_decoder_input;
   logic                 reset;
   logic                 busy;
   logic                 done;
   logic                 paused;
   logic                 error_flag;
   logic [CNT_W-1:0]     total_tests;
   logic [CNT_W-1:0]     total_errors;

   modport master (
      input  start, abort, halt_on_err, continua, chain_input, chain_output,
      output K, mux_decoder_input, reset, busy, done, paused, error_flag,
             total_tests, total_errors
   );

   modport slave (
      output start, abort, halt_on_err, continua, chain_input, chain_output,
      input  K, mux_decoder_input, reset, busy, done, paused, error_flag,
             total_tests, total_errors
   );

endinterface

// File: rtl/chain_test_sequencer_step_tick_gen.sv
// Step pacing divider: counts 0..TICK_DIV-1 while enabled and emits a
// single-cycle tick on the last count.
module step_tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   assign tick = enable && (count == LAST);

endmodule

// File: rtl/chain_test_sequencer.sv
// Scan-chain test sequencer: sweeps every pattern K over every selected chain,
// pulsing DUT reset per chain and accumulating saturating test/error counts.
module chain_test_sequencer
   import chain_test_pkg::*;
#(
   parameter int PATTERN_W   = 6,
   parameter int NUM_CHAINS  = 22,
   parameter int MUX_W       = 5,
   parameter int TICK_DIV    = 50000,
   parameter int RESET_TICKS = 2,
   parameter int CNT_W       = 15
) (
   input logic                    sys_clock,
   input logic                    sys_reset,
   chain_test_sequencer_if.master bus
);

   localparam int RST_CNT_W = (RESET_TICKS > 1) ? $clog2(RESET_TICKS) : 1;
   localparam logic [PATTERN_W-1:0] K_LAST    = '1;
   localparam logic [MUX_W-1:0]     MUX_LAST  = MUX_W'(NUM_CHAINS - 1);
   localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
   localparam logic [RST_CNT_W-1:0] RST_LAST  = RST_CNT_W'(RESET_TICKS - 1);

   seq_state_t           state, state_n;
   logic [PATTERN_W-1:0] k, k_n;
   logic [MUX_W-1:0]     mux, mux_n;
   logic [CNT_W-1:0]     tests, tests_n;
   logic [CNT_W-1:0]     errors, errors_n;
   logic                 err_flag, err_flag_n;
   logic [RST_CNT_W-1:0] rst_cnt, rst_cnt_n;
   logic                 continua_q;
   logic                 tick;
   logic                 div_clear;
   logic                 div_enable;
   logic                 mismatch;
   logic                 resume;

   // The divider only runs in the timed states so APPLY always starts from zero.
   assign div_enable = (state == RST_DUT) || (state == APPLY);
   assign div_clear  = (state_n != state) && (state_n inside {IDLE, RST_DUT, PAUSE});

   step_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk   (sys_clock),
      .rst   (sys_reset),
      .clear (div_clear),
      .enable(div_enable),
      .tick  (tick)
   );

   assign mismatch = is_mismatch(MAX_PATTERN_W'(bus.chain_input),
                                 MAX_PATTERN_W'(bus.chain_output),
                                 MAX_PATTERN_W'(k));
   assign resume   = bus.continua && !continua_q;

   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         state      <= IDLE;
         k          <= '0;
         mux        <= '0;
         tests      <= '0;
         errors     <= '0;
         err_flag   <= 1'b0;
         rst_cnt    <= '0;
         continua_q <= 1'b0;
      end else begin
         state      <= state_n;
         k          <= k_n;
         mux        <= mux_n;
         tests      <= tests_n;
         errors     <= errors_n;
         err_flag   <= err_flag_n;
         rst_cnt    <= rst_cnt_n;
         continua_q <= bus.continua;
      end
   end

   // Abort overrides everything, including the count update of a CHECK cycle.
   always_comb begin
      state_n    = state;
      k_n        = k;
      mux_n      = mux;
      tests_n    = tests;
      errors_n   = errors;
      err_flag_n = err_flag;
      rst_cnt_n  = rst_cnt;
      if (bus.abort) begin
         state_n = IDLE;
         k_n     = '0;
         mux_n   = '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_n    = RST_DUT;
                  k_n        = '0;
                  mux_n      = '0;
                  tests_n    = '0;
                  errors_n   = '0;
                  err_flag_n = 1'b0;
                  rst_cnt_n  = '0;
               end
            end
            RST_DUT: begin
               if (tick) begin
                  if (rst_cnt == RST_LAST) begin
                     state_n   = APPLY;
                     rst_cnt_n = '0;
                  end else begin
                     rst_cnt_n = rst_cnt + 1'b1;
                  end
               end
            end
            APPLY: begin
               if (tick) state_n = CHECK;
            end
            CHECK: begin
               tests_n = (tests == CNT_MAX) ? tests : tests + 1'b1;
               if (mismatch) begin
                  errors_n   = (errors == CNT_MAX) ? errors : errors + 1'b1;
                  err_flag_n = 1'b1;
               end
               state_n = (mismatch && bus.halt_on_err) ? PAUSE : NEXT;
            end
            NEXT: begin
               if (k != K_LAST) begin
                  k_n     = k + 1'b1;
                  state_n = APPLY;
               end else begin
                  k_n = '0;
                  if (mux == MUX_LAST) begin
                     state_n = DONE;
                  end else begin
                     mux_n     = mux + 1'b1;
                     rst_cnt_n = '0;
                     state_n   = RST_DUT;
                  end
               end
            end
            PAUSE: begin
               if (resume) state_n = NEXT;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign bus.K                 = k;
   assign bus.mux_decoder_input = mux;
   assign bus.reset             = (state == RST_DUT);
   assign bus.busy              = (state != IDLE) && (state != DONE);
   assign bus.done              = (state == DONE);
   assign bus.paused            = (state == PAUSE);
   assign bus.error_flag        = err_flag;
   assign bus.total_tests       = tests;
   assign bus.total_errors      = errors;

endmodule
